// File: rtl/tap_period_pkg.sv
// Shared definitions for the tap-tempo path: FSM encoding, time-pulse default
// and the interval counter sizing used by debounce, tap_period and BPM conversion.
package tap_period_pkg;

   localparam int DEF_PULSE_PER_NS = 5120;
   localparam int HIST_DEPTH       = 4;

   typedef enum logic {
      s_idle  = 1'b0,
      s_count = 1'b1
   } tap_state_e;

   function automatic int max_count_f(input int max_ns, input int pulse_ns);
      return max_ns / pulse_ns - 1;
   endfunction

   function automatic int cnt_w_f(input int max_ns, input int pulse_ns);
      return $clog2(max_count_f(max_ns, pulse_ns) + 1);
   endfunction

endpackage

// File: rtl/tap_avg4.sv
// Four-entry tap interval history with saturating fill count; reports the newest
// interval until the history is full, then the truncated mean of all four.
module tap_avg4
   import tap_period_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] din_i,
   output logic [CNT_W-1:0] mean_o
);

   logic [CNT_W-1:0] ent_q [HIST_DEPTH];
   logic [2:0]       fill_q;
   logic [CNT_W+1:0] sum;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < HIST_DEPTH; i++) ent_q[i] <= '0;
         fill_q <= '0;
      end else begin
         if (push_i) begin
            ent_q[0] <= din_i;
            for (int i = 1; i < HIST_DEPTH; i++) ent_q[i] <= ent_q[i-1];
         end
         if (clear_i)
            fill_q <= '0;
         else if (push_i && fill_q != 3'd4)
            fill_q <= fill_q + 3'd1;
      end
   end

   always_comb begin
      sum    = {2'b00, ent_q[0]} + {2'b00, ent_q[1]} + {2'b00, ent_q[2]} + {2'b00, ent_q[3]};
      mean_o = (fill_q == 3'd4) ? sum[CNT_W+1:2] : ent_q[0];
   end

endmodule

// File: rtl/tap_period.sv
// Measures the interval between debounced button taps in tp_i ticks and
// publishes a 4-tap running average, with a timeout when taps stop.
module tap_period
   import tap_period_pkg::*;
#(
   parameter  int PULSE_PER_NS  = DEF_PULSE_PER_NS,
   parameter  int MAX_PERIOD_NS = 2_000_000_000,
   parameter  int AVG_DEPTH     = 4,
   localparam int MAX_COUNT     = max_count_f(MAX_PERIOD_NS, PULSE_PER_NS),
   localparam int CNT_W         = cnt_w_f(MAX_PERIOD_NS, PULSE_PER_NS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tp_i,
   input  logic             btn_i,
   output logic [CNT_W-1:0] period_o,
   output logic             period_valid_o,
   output logic             timeout_o
);

   if (AVG_DEPTH != HIST_DEPTH) begin : g_bad_depth
      $error("tap_period: only AVG_DEPTH = 4 is supported");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

   tap_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_q, arm_q, tap;
   logic             push_p0, clr_p0, timeout_d;
   logic             vld_p1;
   logic [CNT_W-1:0] mean_p1;

   // arm_q stays low until btn_i is seen low after reset, so a level already
   // high at release is not mistaken for a fresh press.
   assign tap = btn_i & ~btn_q & arm_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      push_p0   = 1'b0;
      clr_p0    = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         s_idle: begin
            if (tap) begin
               cnt_d   = '0;
               state_d = s_count;
            end
         end
         s_count: begin
            if (tap) begin
               push_p0 = 1'b1;
               cnt_d   = '0;
            end else if (tp_i) begin
               if (cnt_q == CNT_MAX) begin
                  cnt_d     = '0;
                  clr_p0    = 1'b1;
                  timeout_d = 1'b1;
                  state_d   = s_idle;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = s_idle;
      endcase
   end

   // p0 -> p1: edge detect, FSM, counter and history update
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= s_idle;
         cnt_q     <= '0;
         btn_q     <= 1'b0;
         arm_q     <= 1'b0;
         timeout_o <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         btn_q     <= btn_i;
         arm_q     <= arm_q | ~btn_i;
         timeout_o <= timeout_d;
         vld_p1    <= push_p0;
      end
   end

   tap_avg4 #(.CNT_W(CNT_W)) u_avg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_p0),
      .clear_i (clr_p0),
      .din_i   (cnt_q),
      .mean_o  (mean_p1)
   );

   // p1 -> p2: registered output
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         period_o       <= '0;
         period_valid_o <= 1'b0;
      end else begin
         period_valid_o <= vld_p1;
         if (vld_p1) period_o <= mean_p1;
      end
   end

endmodule

// File: tb/tb_tap_period.sv
// Bench for tap_period with MAX_COUNT = 15: tap interval table plus
// timeout, reset and long-press sequences, checked against a strobe scoreboard.
module tb_tap_period;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       tp_i  = 1'b0;
   logic       btn_i = 1'b0;
   logic [3:0] period_o;
   logic       period_valid_o;
   logic       timeout_o;

   tap_period #(
      .PULSE_PER_NS  (5120),
      .MAX_PERIOD_NS (81920),
      .AVG_DEPTH     (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .tp_i           (tp_i),
      .btn_i          (btn_i),
      .period_o       (period_o),
      .period_valid_o (period_valid_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int val;
      int due;
   } exp_t;

   typedef struct {
      bit rst;
      int ticks;
      bit co;
      bit exp;
      int val;
   } row_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   to_due = -1;
   logic tp_ph = 1'b0;

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic step(input logic b);
      btn_i = b;
      tp_i  = tp_ph;
      tp_ph = ~tp_ph;
      @(posedge clk_i);
      #1;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("strobe", int'(period_valid_o), 1);
         chk("period", int'(period_o), sb[0].val);
         void'(sb.pop_front());
      end else if (period_valid_o) begin
         chk("stray strobe", int'(period_valid_o), 0);
      end
      if (to_due == cyc) begin
         chk("timeout", int'(timeout_o), 1);
         to_due = -1;
      end else if (timeout_o) begin
         chk("stray timeout", int'(timeout_o), 0);
      end
      cyc++;
   endtask

   task automatic run_ticks(input logic b, input int n, input int to_at);
      int p = 0;
      while (p < n) begin
         if (tp_ph) begin
            p++;
            if (p == to_at) to_due = cyc;
         end
         step(b);
      end
   endtask

   task automatic tap(input bit exp, input int val);
      if (exp) sb.push_back('{val, cyc + 1});
      step(1'b1);
   endtask

   task automatic tap_after(input int ticks, input bit co, input bit exp, input int val);
      run_ticks(1'b0, ticks, 0);
      if (co && !tp_ph) step(1'b0);
      tap(exp, val);
   endtask

   task automatic reset_dut(input logic b);
      for (int i = 0; i < 4; i++) step(1'b0);
      rst_i = 1'b1;
      step(b);
      step(b);
      chk("rst period_o", int'(period_o), 0);
      chk("rst period_valid_o", int'(period_valid_o), 0);
      chk("rst timeout_o", int'(timeout_o), 0);
      rst_i = 1'b0;
      step(b);
   endtask

   row_t tbl[$];

   initial begin
      tbl = '{
         '{1, 2, 0, 0, 0}, '{0, 10, 0, 1, 10}, '{0, 10, 0, 1, 10},
         '{1, 2, 0, 0, 0}, '{0, 7, 1, 1, 7}, '{0, 3, 0, 1, 3},
         '{1, 2, 0, 0, 0}, '{0, 15, 1, 1, 15}, '{0, 2, 0, 1, 2}, '{0, 15, 0, 1, 15},
         '{1, 2, 0, 0, 0}, '{0, 8, 0, 1, 8}, '{0, 12, 0, 1, 12}, '{0, 10, 0, 1, 10},
         '{0, 6, 0, 1, 9}, '{0, 15, 0, 1, 10}, '{0, 1, 0, 1, 8}
      };

      step(1'b0);
      step(1'b0);
      reset_dut(1'b0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) reset_dut(1'b0);
         tap_after(tbl[i].ticks, tbl[i].co, tbl[i].exp, tbl[i].val);
      end

      // silence after the reference tap: one timeout, then re-reference
      reset_dut(1'b0);
      tap(0, 0);
      run_ticks(1'b0, 16, 16);
      run_ticks(1'b0, 4, 0);
      tap(0, 0);
      tap_after(5, 0, 1, 5);

      // reset mid-interval while the button is held high
      reset_dut(1'b0);
      tap(0, 0);
      tap_after(6, 0, 1, 6);
      run_ticks(1'b0, 4, 0);
      for (int i = 0; i < 4; i++) step(1'b0);
      rst_i = 1'b1;
      step(1'b1);
      step(1'b1);
      chk("midrst period_o", int'(period_o), 0);
      chk("midrst period_valid_o", int'(period_valid_o), 0);
      chk("midrst timeout_o", int'(timeout_o), 0);
      rst_i = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b1);
      step(1'b0);
      tap(0, 0);
      tap_after(4, 0, 1, 4);

      // long press counts once, then the interval times out while held
      reset_dut(1'b0);
      tap(0, 0);
      tap_after(3, 0, 1, 3);
      begin
         int p = 0;
         for (int i = 0; i < 99; i++) begin
            if (tp_ph) begin
               p++;
               if (p == 16) to_due = cyc;
            end
            step(1'b1);
         end
      end
      step(1'b0);
      tap(0, 0);
      tap_after(5, 0, 1, 5);

      for (int i = 0; i < 6; i++) step(1'b0);
      chk("pending strobes", sb.size(), 0);
      chk("pending timeout", to_due, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
